// File: rtl/ext_bus_sched.sv
// ext_bus_sched: round-robin CPU/DMA sequencer driving the shared external memory bus.
// Define EXTBUS_DMA_EN to build the DMA port and arbiter; otherwise only the CPU is served.
module ext_bus_sched #(
  parameter int unsigned WAIT_CART = 2,
  parameter int unsigned WAIT_SRAM = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_doe,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic        bus_cale,
  output logic        bus_cs
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_CART_C = 3'(WAIT_CART);
  localparam logic [2:0] WAIT_SRAM_C = 3'(WAIT_SRAM);
  localparam logic       PORT_CPU    = 1'b0;

  state_t      state_r, state_s;
  logic [2:0]  wait_r, wait_s;
  logic [15:0] addr_r;
  logic        we_r;
  logic [7:0]  wdata_r;
  logic        port_r;

  logic        gnt_s;
  logic        gnt_port_s;
  logic [15:0] req_addr_s;
  logic        req_we_s;
  logic [7:0]  req_wdata_s;
  logic        ext_s, cart_s;
  logic        rd_int_s, rd_ext_s;

  // Returns {external, cartridge}; 8000-9FFF and FE00-FFFF stay on-chip
  function automatic logic [1:0] decode_target(input logic [15:0] addr);
    logic [1:0] tgt;
    if (addr[15] == 1'b0) begin
      tgt = 2'b11;
    end else if (addr[15:13] == 3'b101) begin
      tgt = 2'b11;
    end else if ((addr[15:14] == 2'b11) && (addr[15:9] != 7'h7F)) begin
      tgt = 2'b10;
    end else begin
      tgt = 2'b00;
    end
    return tgt;
  endfunction

  assign {ext_s, cart_s} = decode_target(addr_r);
  assign rd_int_s = (state_r == ST_ADDR) && !ext_s && !we_r;
  assign rd_ext_s = (state_r == ST_DONE) && ext_s && !we_r;

`ifdef EXTBUS_DMA_EN
  localparam logic PORT_DMA = 1'b1;
  logic last_dma_r;

  // Round-robin pick: on a tie the port not granted last wins
  always_comb begin
    gnt_s = cpu_req | dma_req;
    if (cpu_req && dma_req) begin
      gnt_port_s = ~last_dma_r;
    end else if (dma_req) begin
      gnt_port_s = PORT_DMA;
    end else begin
      gnt_port_s = PORT_CPU;
    end
    if (gnt_port_s == PORT_DMA) begin
      req_addr_s  = dma_addr;
      req_we_s    = dma_we;
      req_wdata_s = dma_wdata;
    end else begin
      req_addr_s  = cpu_addr;
      req_we_s    = cpu_we;
      req_wdata_s = cpu_wdata;
    end
  end

  // Last-grant pointer, reset to DMA so the CPU takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dma_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && gnt_s) begin
      last_dma_r <= gnt_port_s;
    end
  end

  // DMA-side completion pulse and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_ack   <= 1'b0;
      dma_rdata <= 8'h00;
    end else begin
      dma_ack <= (state_r == ST_DONE) && (port_r == PORT_DMA);
      if (rd_int_s && (port_r == PORT_DMA)) begin
        dma_rdata <= 8'hFF;
      end else if (rd_ext_s && (port_r == PORT_DMA)) begin
        dma_rdata <= bus_din;
      end
    end
  end
`else
  logic dma_unused_s;
  assign dma_unused_s = ^{dma_req, dma_we, dma_addr, dma_wdata};
  assign gnt_s        = cpu_req;
  assign gnt_port_s   = PORT_CPU;
  assign req_addr_s   = cpu_addr;
  assign req_we_s     = cpu_we;
  assign req_wdata_s  = cpu_wdata;
  assign dma_ack      = 1'b0;
  assign dma_rdata    = 8'h00;
`endif

  // State, wait counter and the granted transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wait_r  <= 3'd0;
      addr_r  <= 16'h0000;
      we_r    <= 1'b0;
      wdata_r <= 8'h00;
      port_r  <= PORT_CPU;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
      if ((state_r == ST_IDLE) && gnt_s) begin
        addr_r  <= req_addr_s;
        we_r    <= req_we_s;
        wdata_r <= req_wdata_s;
        port_r  <= gnt_port_s;
      end
    end
  end

  // Next-state logic; strobe lasts wait+1 cycles
  always_comb begin
    state_s = state_r;
    wait_s  = wait_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s) begin
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ext_s) begin
          state_s = ST_STROBE;
          wait_s  = cart_s ? WAIT_CART_C : WAIT_SRAM_C;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_STROBE: begin
        if (wait_r == 3'd0) begin
          state_s = ST_DONE;
        end else begin
          wait_s = wait_r - 3'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered pins trail the state by one cycle; read data is taken as the strobe ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_a     <= 16'h0000;
      bus_dout  <= 8'h00;
      bus_cs    <= 1'b0;
      bus_cale  <= 1'b0;
      bus_doe   <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      bus_cale <= (state_r == ST_ADDR) && ext_s;
      bus_doe  <= we_r && (((state_r == ST_ADDR) && ext_s) || (state_r == ST_STROBE));
      bus_rd   <= (state_r == ST_STROBE) && !we_r;
      bus_wr   <= (state_r == ST_STROBE) && we_r;
      cpu_ack  <= (state_r == ST_DONE) && (port_r == PORT_CPU);
      if ((state_r == ST_ADDR) && ext_s) begin
        bus_a  <= addr_r;
        bus_cs <= cart_s;
        if (we_r) begin
          bus_dout <= wdata_r;
        end
      end
      if (rd_int_s && (port_r == PORT_CPU)) begin
        cpu_rdata <= 8'hFF;
      end else if (rd_ext_s && (port_r == PORT_CPU)) begin
        cpu_rdata <= bus_din;
      end
    end
  end

endmodule

// File: tb/tb_ext_bus_sched.sv
// Self-checking bench for ext_bus_sched: directed test-plan cases plus random traffic
// compared against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_ext_bus_sched;

  localparam int WC = 2;
  localparam int WS = 0;
`ifdef EXTBUS_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif
  localparam int N    = 8192;
  localparam int MASK = N - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = 16'h0;
  logic [7:0]  dma_wdata = 8'h0;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h0;
  logic        bus_doe, bus_wr, bus_rd, bus_cale, bus_cs;

  int checks = 0;
  int errors = 0;

  ext_bus_sched #(.WAIT_CART(WC), .WAIT_SRAM(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_din(bus_din), .bus_doe(bus_doe),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_cale(bus_cale), .bus_cs(bus_cs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: per-cycle expected pin timeline ----------------
  bit          e_cale[N], e_rd[N], e_wr[N], e_doe[N], e_cack[N], e_dack[N];
  int          cyc = 0;
  int          free_at = 0;
  bit          last_dma = 1'b1;
  logic [15:0] h_a;
  logic        h_cs;
  logic [7:0]  h_dout;
  logic [7:0]  h_rd[2];
  bit          upd_v, upd_we, upd_cs;
  int          upd_cyc;
  logic [15:0] upd_a;
  logic [7:0]  upd_d;
  bit          cap_v, cap_ff;
  int          cap_cyc, cap_port;

  // 0: on-chip, 1: cartridge, 2: work-RAM
  function automatic int target_of(input logic [15:0] a);
    if (a <= 16'h7FFF || (a >= 16'hA000 && a <= 16'hBFFF)) return 1;
    if (a >= 16'hC000 && a <= 16'hFDFF) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      e_cale[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_doe[i] = 0; e_cack[i] = 0; e_dack[i] = 0;
    end
    free_at = 0; last_dma = 1'b1;
    h_a = 16'h0; h_cs = 1'b0; h_dout = 8'h0; h_rd[0] = 8'h0; h_rd[1] = 8'h0;
    upd_v = 0; cap_v = 0;
  endtask

  task automatic model_step();
    bit cp, dp, we;
    int port, tgt, w;
    logic [15:0] a;
    logic [7:0]  d;
    cyc++;
    if (upd_v && cyc == upd_cyc) begin
      h_a = upd_a; h_cs = upd_cs;
      if (upd_we) h_dout = upd_d;
      upd_v = 0;
    end
    if (cap_v && cyc == cap_cyc) begin
      h_rd[cap_port] = cap_ff ? 8'hFF : bus_din;
      cap_v = 0;
    end
    cp = cpu_req;
    dp = dma_req && DMA_EN;
    if (cyc >= free_at && (cp || dp)) begin
      if (cp && dp) port = last_dma ? 0 : 1;
      else port = cp ? 0 : 1;
      last_dma = (port == 1);
      a  = (port == 1) ? dma_addr : cpu_addr;
      we = (port == 1) ? dma_we : cpu_we;
      d  = (port == 1) ? dma_wdata : cpu_wdata;
      tgt = target_of(a);
      if (tgt != 0) begin
        w = (tgt == 1) ? WC : WS;
        e_cale[(cyc + 1) & MASK] = 1;
        upd_v = 1; upd_cyc = cyc + 1; upd_a = a; upd_cs = (tgt == 1); upd_we = we; upd_d = d;
        for (int i = 1; i <= w + 2; i++) if (we) e_doe[(cyc + i) & MASK] = 1;
        for (int i = 2; i <= w + 2; i++) begin
          if (we) e_wr[(cyc + i) & MASK] = 1;
          else    e_rd[(cyc + i) & MASK] = 1;
        end
        if (port == 0) e_cack[(cyc + w + 3) & MASK] = 1;
        else           e_dack[(cyc + w + 3) & MASK] = 1;
        if (!we) begin cap_v = 1; cap_cyc = cyc + w + 3; cap_port = port; cap_ff = 0; end
        free_at = cyc + w + 4;
      end else begin
        if (port == 0) e_cack[(cyc + 2) & MASK] = 1;
        else           e_dack[(cyc + 2) & MASK] = 1;
        if (!we) begin cap_v = 1; cap_cyc = cyc + 1; cap_port = port; cap_ff = 1; end
        free_at = cyc + 3;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  // Compare every cycle against the model, mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      int i;
      i = cyc & MASK;
      check_eq("bus_cale", bus_cale, e_cale[i]);
      check_eq("bus_rd",   bus_rd,   e_rd[i]);
      check_eq("bus_wr",   bus_wr,   e_wr[i]);
      check_eq("bus_doe",  bus_doe,  e_doe[i]);
      check_eq("cpu_ack",  cpu_ack,  e_cack[i]);
      check_eq("dma_ack",  dma_ack,  e_dack[i]);
      check_eq("bus_a",    bus_a,    h_a);
      check_eq("bus_cs",   bus_cs,   h_cs);
      check_eq("bus_dout", bus_dout, h_dout);
      check_eq("cpu_rdata", cpu_rdata, h_rd[0]);
      check_eq("dma_rdata", dma_rdata, h_rd[1]);
      e_cale[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_doe[i] = 0; e_cack[i] = 0; e_dack[i] = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, bus_a, 16'h0);
    check_eq({tag, "_dout"}, bus_dout, 8'h0);
    check_eq({tag, "_strobes"}, {bus_cale, bus_rd, bus_wr, bus_doe, bus_cs}, 5'b0);
    check_eq({tag, "_acks"}, {cpu_ack, dma_ack}, 2'b0);
    check_eq({tag, "_rdata"}, {cpu_rdata, dma_rdata}, 16'h0);
  endtask

  task automatic txn(input int port, input bit we, input logic [15:0] a, input logic [7:0] d,
                     output int lat);
    bit got;
    @(negedge clk);
    if (port == 0) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    else           begin dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
    lat = 0; got = 0;
    while (!got && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      if ((port == 0) ? cpu_ack : dma_ack) got = 1;
      else lat++;
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    if (port == 0) cpu_req = 1'b0;
    else dma_req = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 16'($urandom_range(16'h0000, 16'h7FFF));
      1: return 16'($urandom_range(16'hA000, 16'hBFFF));
      2: return 16'($urandom_range(16'hC000, 16'hFDFF));
      3: return 16'($urandom_range(16'h8000, 16'h9FFF));
      4: return 16'($urandom_range(16'hFE00, 16'hFFFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, n, guard;
    int order[3];
    bit seen;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    bus_din = 8'h3C;

`ifdef EXTBUS_DMA_EN
    // Simultaneous requests straight after reset: CPU first, then alternate
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'hD000; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 16'h4000; dma_req = 1'b1;
    n = 0; guard = 0;
    while (n < 3 && guard < 80) begin
      @(negedge clk);
      guard++;
      check_eq("ack_overlap", cpu_ack & dma_ack, 1'b0);
      if (cpu_ack) begin order[n] = 0; n++; end
      else if (dma_ack) begin order[n] = 1; n++; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check_eq("tie_count", n, 3);
    check_eq("tie_order0", order[0], 0);
    check_eq("tie_order1", order[1], 1);
    check_eq("tie_order2", order[2], 0);
`endif

    // CPU cartridge read
    txn(0, 1'b0, 16'h0134, 8'h00, lat);
    check_eq("cart_rd_lat", lat, WC + 3);
    check_eq("cart_rd_data", cpu_rdata, 8'h3C);
    check_eq("cart_rd_a", bus_a, 16'h0134);
    check_eq("cart_rd_cs", bus_cs, 1'b1);

    // CPU work-RAM write
    txn(0, 1'b1, 16'hC123, 8'h5A, lat);
    check_eq("sram_wr_lat", lat, WS + 3);
    check_eq("sram_wr_dout", bus_dout, 8'h5A);
    check_eq("sram_wr_cs", bus_cs, 1'b0);

`ifdef EXTBUS_DMA_EN
    // DMA read of an on-chip address
    txn(1, 1'b0, 16'hFF44, 8'h00, lat);
    check_eq("int_rd_lat", lat, 2);
    check_eq("int_rd_data", dma_rdata, 8'hFF);
`else
    // DMA held high must never be served
    @(negedge clk);
    dma_we = 1'b0; dma_addr = 16'h1000; dma_req = 1'b1;
    txn(0, 1'b0, 16'hA010, 8'h00, lat);
    check_eq("nodma_cpu_lat", lat, WC + 3);
    txn(0, 1'b0, 16'hFF44, 8'h00, lat);
    check_eq("nodma_int_lat", lat, 2);
    check_eq("nodma_int_data", cpu_rdata, 8'hFF);
    check_eq("nodma_ack", dma_ack, 1'b0);
    check_eq("nodma_rdata", dma_rdata, 8'h00);
    dma_req = 1'b0;
`endif

    // Reset during the strobe of a cartridge write
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    guard = 0; seen = 0;
    while (!seen && guard < 20) begin
      @(negedge clk);
      guard++;
      if (bus_wr) seen = 1;
    end
    check_eq("wr_before_rst", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_async_wr", bus_wr, 1'b0);
    check_eq("rst_async_ack", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    txn(0, 1'b0, 16'h0150, 8'h00, lat);
    check_eq("post_rst_lat", lat, WC + 3);
    check_eq("post_rst_data", cpu_rdata, 8'h3C);

    // Random traffic from both masters
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus_din = 8'($urandom);
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_addr = rand_addr(); cpu_we = 1'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1'b1;
      end
      if (dma_req && dma_ack) dma_req = 1'b0;
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_addr = rand_addr(); dma_we = 1'($urandom); dma_wdata = 8'($urandom); dma_req = 1'b1;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (dma_req && dma_ack) dma_req = 1'b0;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_bus_sched.md
# ext_bus_sched

Sequencer and two-port arbiter for the chip's shared external memory bus. The CPU and DMA engine each issue simple request/acknowledge transactions. The block arbitrates between them round-robin, decodes cartridge versus work-RAM targets, and drives the multiplexed bus pins. These are the address with latch enable, data out/in, output enable, read/write strobes and chip select, with per-target wait states. It sits between the core-side masters and the chip pads feeding the cartridge and the external SRAM.

## Interface
- `WAIT_CART`, default 2: extra strobe cycles for cartridge accesses (0–7).
- `WAIT_SRAM`, default 0: extra strobe cycles for work-RAM accesses (0–7).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req` in 1: CPU request; held high with `cpu_addr`, `cpu_we` and `cpu_wdata` stable until `cpu_ack`.
- `cpu_we` in 1: 1 selects write, 0 selects read.
- `cpu_addr` in 16: CPU byte address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data; valid with `cpu_ack` and held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU port, for the DMA master.
- `bus_a` out 16: external address.
- `bus_dout` out 8: external write data.
- `bus_din` in 8: external read data.
- `bus_doe` out 1: data output enable.
- `bus_wr` out 1: write strobe.
- `bus_rd` out 1: read strobe.
- `bus_cale` out 1: address latch enable.
- `bus_cs` out 1: 1 selects the cartridge, 0 selects the work-RAM SRAM.

## Operation
- **States:** IDLE, ADDR, STROBE, DONE.
- **IDLE:**
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant it.
  - Both pending: grant the port not granted last. The last-grant pointer resets to DMA, so the CPU wins the first tie.
  - On grant: register address, we, wdata and port id; go to ADDR.
- **Decode** of the registered address:
  - 0000–7FFF and A000–BFFF: cartridge, `bus_cs`=1.
  - C000–FDFF: SRAM, `bus_cs`=0. This includes the E000–FDFF echo region.
  - 8000–9FFF and FE00–FFFF: internal, no external cycle.
- **ADDR:**
  - External target: `bus_a` = address and `bus_cale`=1 for one cycle. For writes, `bus_dout` = wdata and `bus_doe`=1. Next state STROBE, with wait counter loaded with `WAIT_CART` or `WAIT_SRAM`.
  - Internal target: no strobe, `bus_cale`=0, rdata forced to 8'hFF; next state DONE.
- **STROBE:** assert `bus_rd` (read) or `bus_wr` (write). Decrement the counter each cycle; leave when it is 0, so the strobe lasts wait+1 cycles. On the exiting edge of a read, capture `bus_din` into the granted port's rdata register.
- **DONE:** pulse the granted port's ack; deassert strobes, `bus_doe` and `bus_cale`. Next state is always IDLE (one turnaround cycle).
- **Held outputs:** `bus_a`, `bus_cs` and `bus_dout` hold from ADDR until the next grant.
- **Committed transactions:** a granted transaction always runs to completion, even if its requester drops req mid-cycle. The ack is still issued and the requester ignores it.
- **Ack exclusivity:** ack is never asserted on the non-granted port. `cpu_ack` and `dma_ack` are never high together.

## Timing
- **Reset values:** all outputs 0, including `bus_a`=0000, `bus_cs`=0, `cpu_rdata`=`dma_rdata`=00; state IDLE; last-grant pointer = DMA.
- **Reset mid-transaction:** immediate return to IDLE, strobes drop asynchronously, no ack issued.
- **Latency, external access:** with req sampled high in IDLE at edge k, ADDR occupies cycle k+1 and STROBE occupies W+1 cycles. Ack is high in the cycle starting W+3 edges after k.
- **Latency, internal address:** ack 2 cycles after the grant edge.
- **Back-to-back requests** from the same port: minimum period W+4 cycles (external).
- **Data setup:** `bus_din` must be valid at the last STROBE edge.
- **Strobe exclusivity:** `bus_wr` and `bus_rd` are never high together.

## Configuration
- **`EXTBUS_DMA_EN`** defined:
  - Two-port round-robin arbitration as described above.
- **`EXTBUS_DMA_EN`** undefined:
  - DMA inputs are ignored and `dma_ack`/`dma_rdata` are tied 0.
  - Only `cpu_req` can grant, and no last-grant pointer is built.
  - All timing is unchanged.

## Test plan
- **CPU cartridge read:** CPU read 0x0134, `WAIT_CART`=2, `bus_din`=8'h3C.
  - `bus_cale` pulses one cycle with `bus_a`=0134 and `bus_cs`=1.
  - `bus_rd` is high 3 cycles.
  - `cpu_ack` arrives 5 cycles after the req edge with `cpu_rdata`=3C.
- **CPU SRAM write:** CPU write 0xC123 ← 8'h5A, `WAIT_SRAM`=0.
  - `bus_cs`=0, `bus_doe` high ADDR–STROBE.
  - `bus_wr` high exactly 1 cycle with `bus_dout`=5A.
  - ack after 3 cycles; `bus_rd` stays 0.
- **Simultaneous requests after reset:** CPU read 0xD000 and DMA read 0x4000.
  - CPU is served first, then DMA.
  - With both requests held continuously, grants alternate CPU, DMA, CPU; acks never overlap.
- **Internal address:** DMA read 0xFF44.
  - No `bus_cale`, `bus_rd` or `bus_wr` activity.
  - `dma_ack` after 2 cycles with `dma_rdata`=FF.
- **Reset mid-transaction:** assert `rst_n`=0 during STROBE of a cartridge write.
  - `bus_wr` drops immediately and no ack is issued.
  - After release, all outputs read 0.
  - A new CPU request completes normally.
- **`EXTBUS_DMA_EN` undefined:** `dma_req` held high.
  - Never granted; `dma_ack` stays 0.
  - CPU requests complete with unchanged latency.
